// File: rtl/uart_irq_arbiter_pkg.sv
// Shared definitions for the UART interrupt arbiter: register map, CTRL bits, FSM states.
package uart_irq_arbiter_pkg;

    localparam logic [1:0] UIA_MASK = 2'd0;
    localparam logic [1:0] UIA_PEND = 2'd1;
    localparam logic [1:0] UIA_VEC  = 2'd2;
    localparam logic [1:0] UIA_CTRL = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

endpackage

// File: rtl/uart_irq_arbiter_if.sv
// Host register bus of the interrupt arbiter; strobes are active-low and asynchronous to clk.
interface uart_irq_arbiter_if;
    logic       cs_n;
    logic       re_n;
    logic       we_n;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output cs_n, re_n, we_n, addr, wdata, input rdata);
    modport slave  (input cs_n, re_n, we_n, addr, wdata, output rdata);
endinterface

// File: rtl/uart_irq_rr_pick.sv
// Combinational channel picker: round-robin starting after rr_ptr, or fixed with ch0 highest.
module uart_irq_rr_pick #(
    parameter int NCH  = 8,
    parameter int CH_W = 3
) (
    input  logic [NCH-1:0]  pend,
    input  logic [CH_W-1:0] rr_ptr,
    input  logic            mode,
    output logic [CH_W-1:0] ch,
    output logic            any
);

    function automatic logic [CH_W-1:0] wrap(input logic [CH_W-1:0] p, input int i);
        int j;
        j = int'(p) + i;
        if (j >= NCH) j = j - NCH;
        return CH_W'(j);
    endfunction

    // Scan from the far end so the last hit is the closest candidate.
    always_comb begin
        ch  = '0;
        any = |pend;
        for (int i = NCH; i >= 1; i--) begin
            if (mode) begin
                if (pend[CH_W'(i-1)]) ch = CH_W'(i-1);
            end else begin
                if (pend[wrap(rr_ptr, i)]) ch = wrap(rr_ptr, i);
            end
        end
    end

endmodule

// File: rtl/uart_irq_arbiter.sv
// Interrupt arbiter for the UART bank: synchronises channel irqs and host strobes,
// grants one channel at a time and holds it until the host reads the vector and writes EOI.
module uart_irq_arbiter
    import uart_irq_arbiter_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int CH_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     irq_in,
    uart_irq_arbiter_if.slave  bus,
    output logic               irq_out
);

    logic [NCH-1:0]  irq_m, irq_s, pend, mask;
    logic [2:0]      ctl_m, ctl_s;     // {cs_n, re_n, we_n}
    logic            re_d, we_d;
    logic [1:0]      ctrl;
    logic            en, mode, wr_ev, rd_done, eoi, any, valid;
    logic [CH_W-1:0] vector, rr_ptr, pick_ch;
    state_t          state, state_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_m <= '0;
            irq_s <= '0;
            ctl_m <= '1;
            ctl_s <= '1;
            re_d  <= 1'b1;
            we_d  <= 1'b1;
        end else begin
            irq_m <= irq_in;
            irq_s <= irq_m;
            ctl_m <= {bus.cs_n, bus.re_n, bus.we_n};
            ctl_s <= ctl_m;
            re_d  <= ctl_s[1];
            we_d  <= ctl_s[0];
        end
    end

    assign pend    = irq_s & mask;
    assign en      = ctrl[CTRL_EN];
    assign mode    = ctrl[CTRL_MODE];
    assign wr_ev   = we_d & ~ctl_s[0] & ~ctl_s[2];
    assign rd_done = ~re_d & ctl_s[1] & ~ctl_s[2] & (bus.addr == UIA_VEC);
    assign eoi     = wr_ev & (bus.addr == UIA_VEC) & (bus.wdata[CH_W-1:0] == vector);
    assign valid   = (state == ST_ASSERT) || (state == ST_SERVICE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
            ctrl <= '0;
        end else if (wr_ev) begin
            if (bus.addr == UIA_MASK) mask <= bus.wdata[NCH-1:0];
            if (bus.addr == UIA_CTRL) ctrl <= bus.wdata[1:0];
        end
    end

    uart_irq_rr_pick #(.NCH(NCH), .CH_W(CH_W)) u_pick (
        .pend   (pend),
        .rr_ptr (rr_ptr),
        .mode   (mode),
        .ch     (pick_ch),
        .any    (any)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (en && (|pend)) state_n = ST_ARB;
            ST_ARB:     state_n = any ? ST_ASSERT : ST_IDLE;
            ST_ASSERT: begin
                // A read-done beats a same-cycle withdraw.
                if (rd_done)                   state_n = ST_SERVICE;
                else if (!pend[vector] || !en) state_n = ST_IDLE;
            end
            ST_SERVICE: if (eoi || !en) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            vector  <= '0;
            rr_ptr  <= CH_W'(NCH-1);
            irq_out <= 1'b0;
        end else begin
            state   <= state_n;
            irq_out <= (state_n == ST_ASSERT);
            if (state == ST_ARB) vector <= pick_ch;
            if (state == ST_ASSERT && rd_done) rr_ptr <= vector;
        end
    end

    // Vector reads as all-zero when nothing is granted, so a stale channel is never reported.
    always_comb begin
        bus.rdata = 8'h00;
        case (bus.addr)
            UIA_MASK: bus.rdata = 8'(mask);
            UIA_PEND: bus.rdata = 8'(pend);
            UIA_VEC:  bus.rdata = valid ? {1'b1, {(7-CH_W){1'b0}}, vector} : 8'h00;
            UIA_CTRL: bus.rdata = {6'b0, ctrl};
            default:  bus.rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_irq_arbiter.sv
// Scoreboard bench for uart_irq_arbiter: expected reads and irq_out edges are queued, monitors compare.
module tb_uart_irq_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       irq_out;

    uart_irq_arbiter_if bus();

    uart_irq_arbiter #(.NCH(8), .CH_W(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .bus     (bus.slave),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    logic    irq_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    logic    irq_prev = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Read monitor: rdata sampled as the host releases re_n.
    always @(posedge bus.re_n) begin
        rd_exp_t e;
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            check(e.name, bus.rdata, e.exp);
        end
    end

    // irq_out monitor: every change must match the next queued edge.
    always @(negedge clk) begin
        if (irq_out !== irq_prev) begin
            if (irq_q.size() == 0)
                check("irq_unexpected_edge", {7'b0, irq_out}, {7'b0, irq_prev});
            else
                check("irq_edge", {7'b0, irq_out}, {7'b0, irq_q.pop_front()});
            irq_prev <= irq_out;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); bus.addr = a; bus.wdata = d; bus.cs_n = 1'b0;
        @(negedge clk); bus.we_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.we_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.cs_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
        @(negedge clk); bus.addr = a; bus.cs_n = 1'b0;
        rd_q.push_back('{name, exp});
        @(negedge clk); bus.re_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.re_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.cs_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_irq(input logic lvl, input int max, input string name, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (irq_out !== lvl && cnt < max);
        check(name, {7'b0, irq_out}, {7'b0, lvl});
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset = 1'b0; irq_in = 8'h00;
        bus.cs_n = 1'b1; bus.re_n = 1'b1; bus.we_n = 1'b1;
        bus.addr = 2'd0; bus.wdata = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_irq_out", {7'b0, irq_out}, 8'h00);
        check("rst_rdata_mask", bus.rdata, 8'h00);
        @(negedge clk); reset = 1'b1;
        bus_read(2'd0, 8'h00, "rst_mask");
        bus_read(2'd1, 8'h00, "rst_pend");
        bus_read(2'd2, 8'h00, "rst_vec");
        bus_read(2'd3, 8'h00, "rst_ctrl");

        // 1: latency and first grant
        bus_write(2'd0, 8'hFF);
        bus_read(2'd0, 8'hFF, "t1_mask_rb");
        bus_write(2'd3, 8'hFD);
        bus_read(2'd3, 8'h01, "t1_ctrl_rb");
        irq_in = 8'h04;
        irq_q.push_back(1'b1);
        wait_irq(1'b1, 20, "t1_irq_rise", cnt);
        check("t1_latency", 8'(cnt), 8'd4);
        bus_read(2'd1, 8'h04, "t1_pend");
        irq_q.push_back(1'b0);
        bus_read(2'd2, 8'h82, "t1_vec");
        irq_in = 8'h00;
        bus_write(2'd2, 8'h02);
        bus_read(2'd2, 8'h00, "t1_vec_after_eoi");

        // 2: round-robin from rr_ptr=7
        do_reset();
        bus_write(2'd0, 8'hFF);
        bus_write(2'd3, 8'h01);
        irq_in = 8'h81;
        irq_q.push_back(1'b1);
        wait_irq(1'b1, 20, "t2_rise0", cnt);
        irq_q.push_back(1'b0);
        bus_read(2'd2, 8'h80, "t2_vec0");
        irq_q.push_back(1'b1);
        bus_write(2'd2, 8'h00);
        wait_irq(1'b1, 20, "t2_rise1", cnt);
        irq_q.push_back(1'b0);
        bus_read(2'd2, 8'h87, "t2_vec1");
        irq_q.push_back(1'b1);
        bus_write(2'd2, 8'h07);
        wait_irq(1'b1, 20, "t2_rise2", cnt);
        irq_q.push_back(1'b0);
        bus_read(2'd2, 8'h80, "t2_vec2");
        irq_in = 8'h00;
        bus_write(2'd2, 8'h00);

        // 3: fixed priority, ch4 wins over ch5 every time
        bus_write(2'd3, 8'h03);
        irq_in = 8'h30;
        irq_q.push_back(1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_irq(1'b1, 20, "t3_rise", cnt);
            irq_q.push_back(1'b0);
            bus_read(2'd2, 8'h84, "t3_vec");
            if (k == 2) irq_in = 8'h00;
            else        irq_q.push_back(1'b1);
            bus_write(2'd2, 8'h04);
        end

        // 4: withdraw before read
        bus_write(2'd3, 8'h01);
        irq_in = 8'h20;
        irq_q.push_back(1'b1);
        wait_irq(1'b1, 20, "t4_rise", cnt);
        @(negedge clk); irq_in = 8'h00;
        irq_q.push_back(1'b0);
        wait_irq(1'b0, 10, "t4_fall", cnt);
        check("t4_fall_latency", 8'(cnt), 8'd3);
        bus_read(2'd2, 8'h00, "t4_vec");

        // 5: mismatched EOI is ignored
        irq_in = 8'h04;
        irq_q.push_back(1'b1);
        wait_irq(1'b1, 20, "t5_rise", cnt);
        irq_q.push_back(1'b0);
        bus_read(2'd2, 8'h82, "t5_vec");
        irq_in = 8'h00;
        bus_write(2'd2, 8'h03);
        bus_read(2'd2, 8'h82, "t5_vec_bad_eoi");
        bus_write(2'd2, 8'h02);
        bus_read(2'd2, 8'h00, "t5_vec_good_eoi");

        // 6: async reset while in service
        irq_in = 8'h08;
        irq_q.push_back(1'b1);
        wait_irq(1'b1, 20, "t6_rise", cnt);
        irq_q.push_back(1'b0);
        bus_read(2'd2, 8'h83, "t6_vec");
        @(negedge clk); bus.addr = 2'd0;
        #2 reset = 1'b0;
        #1;
        check("t6_rst_rdata", bus.rdata, 8'h00);
        check("t6_rst_irq", {7'b0, irq_out}, 8'h00);
        @(negedge clk); reset = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_grant", {7'b0, irq_out}, 8'h00);
        bus_read(2'd1, 8'h00, "t6_pend_masked");
        bus_read(2'd2, 8'h00, "t6_vec_idle");
        bus_write(2'd0, 8'hFF);
        irq_q.push_back(1'b1);
        bus_write(2'd3, 8'h01);
        wait_irq(1'b1, 20, "t6_rise2", cnt);
        irq_q.push_back(1'b0);
        bus_read(2'd2, 8'h83, "t6_vec2");
        irq_in = 8'h00;
        bus_write(2'd2, 8'h03);

        repeat (5) @(negedge clk);
        check("rd_q_drained", 8'(rd_q.size()), 8'd0);
        check("irq_q_drained", 8'(irq_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
